bure_if_stage: RTL and testbench

Instruction-fetch stage of the Bure RV32 pipeline. It owns the architectural fetch PC, issues in-order requests to the instruction memory, and buffers returned words in a small FIFO. It presents instructions to the decode stage with a valid/ready handshake and accepts PC redirects (new_pc/prst) from downstream stages, discarding stale in-flight fetches after a redirect.

---
 rtl/bure_if_stage.sv | 81 ++++++++
 tb/tb_bure_if_stage.sv | 119 +++++++++++
 2 files changed

// File: rtl/bure_if_stage.sv
// bure_if_stage: RV32 fetch stage with credit-limited in-order requests, an instruction FIFO,
// and PC redirect that flushes the buffer and drops stale in-flight responses.
module bure_if_stage #(
  parameter int ADDR_WIDTH = 32,
  parameter int INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   prst,
  input  logic [ADDR_WIDTH-1:0]  new_pc,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [ADDR_WIDTH-1:0]  imem_req_addr,
  input  logic                   imem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
  output logic                   instr_valid,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0]  instr_pc,
  input  logic                   instr_ready
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_WIDTH-1:0] ALIGN = ~ADDR_WIDTH'(3);
  logic [INSTR_WIDTH-1:0] r_data [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]  r_dpc  [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]  r_tag  [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]  r_pc;
  logic [CW-1:0] r_wp, r_rp, r_tw, r_tr, r_out, r_drop;
  logic [CW-1:0] w_cnt;
  logic [CW:0]   w_used;
  logic w_accept, w_push, w_pop, w_empty;
  assign w_cnt = r_wp - r_rp;
  assign w_used = {1'b0, r_out} + {1'b0, w_cnt};
  assign w_empty = w_cnt == '0;
  // Buffered plus in-flight words never exceed the FIFO, so every response has a slot.
  assign imem_req_valid = !prst && !rst && w_used < (CW+1)'(FIFO_DEPTH);
  assign imem_req_addr = r_pc;
  assign w_accept = imem_req_valid && imem_req_ready;
  assign w_push = imem_rsp_valid && !prst && r_drop == '0;
  assign w_pop = instr_valid && instr_ready && !prst;
  assign instr_valid = !w_empty;
  assign instr = w_empty ? '0 : r_data[r_rp[PW-1:0]];
  assign instr_pc = w_empty ? '0 : r_dpc[r_rp[PW-1:0]];
  always_ff @(posedge clk) begin
    if (w_accept) r_tag[r_tw[PW-1:0]] <= r_pc;
    if (w_push) begin
      r_data[r_wp[PW-1:0]] <= imem_rsp_data;
      r_dpc[r_wp[PW-1:0]] <= r_tag[r_tr[PW-1:0]];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC & ALIGN;
      r_wp <= '0;
      r_rp <= '0;
      r_tw <= '0;
      r_tr <= '0;
      r_out <= '0;
      r_drop <= '0;
    end else begin
      r_out <= r_out + CW'(w_accept) - CW'(imem_rsp_valid);
      r_tw <= r_tw + CW'(w_accept);
      r_tr <= r_tr + CW'(imem_rsp_valid);
      r_wp <= r_wp + CW'(w_push);
      if (prst) begin
        r_pc <= new_pc & ALIGN;
        r_rp <= r_wp;
        r_drop <= r_out - CW'(imem_rsp_valid);
      end else begin
        r_pc <= w_accept ? r_pc + ADDR_WIDTH'(4) : r_pc;
        r_rp <= r_rp + CW'(w_pop);
        r_drop <= r_drop - CW'(imem_rsp_valid && r_drop != '0);
      end
    end
  end
  a_rsp_outstanding: assert property (@(posedge clk) disable iff (rst) imem_rsp_valid |-> r_out != '0);
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) w_push |-> w_cnt != CW'(FIFO_DEPTH));
  a_addr_aligned: assert property (@(posedge clk) disable iff (rst) imem_req_addr[1:0] == 2'b00);
endmodule

// File: tb/tb_bure_if_stage.sv
// tb_bure_if_stage: directed and random fetch traffic against a queue-based fetch model
// with an in-order variable-latency instruction memory.
module tb_bure_if_stage;
  localparam int D = 2;
  logic clk = 0;
  logic rst, prst, imem_req_valid, imem_req_ready, imem_rsp_valid, instr_valid, instr_ready;
  logic [31:0] new_pc, imem_req_addr, imem_rsp_data, instr, instr_pc;
  always #5 clk = ~clk;
  bure_if_stage #(.FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .prst(prst), .new_pc(new_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready)
  );
  int pass_n = 0, fail_n = 0, total_n = 0, cyc = 0, last_due = 0;
  int lat_min = 1, lat_max = 1;
  logic [31:0] mq_addr[$];
  int mq_due[$];
  logic [31:0] m_pc = 0;
  logic [31:0] f_data[$], f_pc[$], i_pc[$];
  bit i_stale[$];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_n++;
    assert (got === exp) pass_n++;
    else begin
      fail_n++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input logic r, input logic p, input logic [31:0] np, input logic ir, input logic qr);
    logic rv, exp_rv, st;
    logic [31:0] rd;
    int lat, due;
    rst = r; prst = p; new_pc = np; instr_ready = ir; imem_req_ready = qr;
    rv = !r && mq_due.size() > 0 && mq_due[0] == cyc;
    rd = rv ? (mq_addr[0] ^ 32'hDEAD_BEEF) : $urandom;
    imem_rsp_valid = rv; imem_rsp_data = rd;
    #1;
    exp_rv = !r && !p && (i_pc.size() + f_data.size() < D);
    chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    chk("req_addr", imem_req_addr, m_pc);
    chk("instr_valid", 32'(instr_valid), 32'(f_data.size() > 0));
    chk("instr", instr, f_data.size() > 0 ? f_data[0] : 32'h0);
    chk("instr_pc", instr_pc, f_pc.size() > 0 ? f_pc[0] : 32'h0);
    if (r) begin
      m_pc = 0; f_data = {}; f_pc = {}; i_pc = {}; i_stale = {};
      mq_addr = {}; mq_due = {}; last_due = cyc;
    end else begin
      if (!p && f_data.size() > 0 && ir) begin
        void'(f_data.pop_front()); void'(f_pc.pop_front());
      end
      if (rv) begin
        st = i_stale.pop_front();
        if (!p && !st) begin f_data.push_back(rd); f_pc.push_back(i_pc[0]); end
        void'(i_pc.pop_front()); void'(mq_addr.pop_front()); void'(mq_due.pop_front());
      end
      if (p) begin
        f_data = {}; f_pc = {};
        foreach (i_stale[k]) i_stale[k] = 1;
        m_pc = np & ~32'h3;
      end else if (exp_rv && qr) begin
        lat = $urandom_range(lat_max, lat_min);
        due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
        last_due = due;
        i_pc.push_back(m_pc); i_stale.push_back(0);
        mq_addr.push_back(m_pc); mq_due.push_back(due);
        m_pc = m_pc + 4;
      end
    end
    @(posedge clk); #1;
    cyc++;
  endtask
  initial begin
    bit found;
    rst = 1; prst = 0; new_pc = 0; instr_ready = 0; imem_req_ready = 0;
    imem_rsp_valid = 0; imem_rsp_data = 0;
    @(posedge clk); #1;
    step(1, 0, 0, 0, 0);
    repeat (8) step(0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0, 1);
    chk("stall_no_req", 32'(imem_req_valid), 32'h0);
    repeat (5) step(0, 0, 0, 1, 1);
    lat_min = 3; lat_max = 3;
    step(1, 0, 0, 0, 0);
    repeat (2) step(0, 0, 0, 1, 1);
    step(0, 1, 32'h100, 1, 1);
    chk("redir_addr", imem_req_addr, 32'h100);
    repeat (10) step(0, 0, 0, 1, 1);
    step(0, 1, 32'h203, 1, 1);
    chk("redir_align", imem_req_addr, 32'h200);
    lat_min = 2; lat_max = 2;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (mq_due.size() > 0 && mq_due[0] == cyc && f_data.size() > 0) found = 1;
      else step(0, 0, 0, 1, 1);
    end
    chk("rsp_due_found", 32'(found), 32'h1);
    step(0, 1, 32'h300, 1, 1);
    chk("prst_rsp_drop", 32'(instr_valid), 32'h0);
    repeat (10) step(0, 0, 0, 1, 1);
    lat_min = 1; lat_max = 1;
    step(1, 0, 0, 0, 0);
    step(0, 1, 32'hFFFF_FFFC, 1, 1);
    step(0, 0, 0, 1, 1);
    chk("pc_wrap", imem_req_addr, 32'h0);
    repeat (6) step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    chk("rst_instr_valid", 32'(instr_valid), 32'h0);
    chk("rst_pc", imem_req_addr, 32'h0);
    repeat (6) step(0, 0, 0, 1, 1);
    lat_min = 1; lat_max = 4;
    for (int k = 0; k < 3000; k++)
      step($urandom_range(299, 0) == 0, $urandom_range(19, 0) == 0,
           $urandom, $urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
